// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and word type for the synchronous FIFO
package fifo_pkg;

   localparam int LANE_W      = 72;
   localparam int FIFO_LANES  = 4;
   localparam int FIFO_DATA_W = FIFO_LANES * LANE_W;

   typedef logic [FIFO_DATA_W-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM with one write port and a registered read port
module fifo_mem #(
   parameter int WIDTH = 288,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage array has no reset so it stays inferable as block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output register clears on reset, matching the RAM's output-latch reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data, status flags and error pulses
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_DATA_W,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   write_en,
   input  logic [WIDTH-1:0]       write_dt,
   input  logic                   read_en,
   output logic [WIDTH-1:0]       read_dt,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_ok;
   logic          rd_ok;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // A read on a full FIFO frees a slot, so the write may proceed in the same cycle.
   assign rd_ok = read_en && !empty;
   assign wr_ok = write_en && (!full || read_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         overflow  <= write_en && full && !read_en;
         underflow <= read_en && empty;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_ok && !rst),
      .waddr (wr_ptr),
      .wdata (write_dt),
      .re    (rd_ok),
      .raddr (rd_ptr),
      .rdata (read_dt)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo against a queue model
module tb_sync_fifo;
   import fifo_pkg::*;

   localparam int WIDTH = FIFO_DATA_W;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             write_en;
   fifo_word_t       write_dt;
   logic             read_en;
   fifo_word_t       read_dt;
   logic             full;
   logic             empty;
   logic [AW:0]      count;
   logic             overflow;
   logic             underflow;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   fifo_word_t q[$];
   fifo_word_t m_rd;
   bit         m_ovf;
   bit         m_udf;

   always #5 clk = ~clk;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .write_en  (write_en),
      .write_dt  (write_dt),
      .read_en   (read_en),
      .read_dt   (read_dt),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   function automatic fifo_word_t word_of(input int v);
      return fifo_word_t'(v);
   endfunction

   function automatic fifo_word_t pat(input int i);
      fifo_word_t w;
      for (int l = 0; l < FIFO_LANES; l++) begin
         w[l*LANE_W +: LANE_W] = LANE_W'(i) + (LANE_W'(l + 1) << 64);
      end
      return w;
   endfunction

   task automatic check_w(input string name, input fifo_word_t act, input fifo_word_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_n(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: FIFO as a queue, rules applied to the pre-edge occupancy.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_rd  = '0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         bit was_full;
         bit was_empty;
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         m_ovf = write_en && was_full && !read_en;
         m_udf = read_en && was_empty;
         if (read_en && !was_empty) m_rd = q.pop_front();
         if (write_en && (!was_full || read_en)) q.push_back(write_dt);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_n("count",     int'(count),     q.size());
         check_n("full",      int'(full),      int'(q.size() == DEPTH));
         check_n("empty",     int'(empty),     int'(q.size() == 0));
         check_n("overflow",  int'(overflow),  int'(m_ovf));
         check_n("underflow", int'(underflow), int'(m_udf));
         check_w("read_dt",   read_dt,         m_rd);
      end
   end

   task automatic cyc(input logic we, input fifo_word_t wd, input logic re);
      write_en = we;
      write_dt = wd;
      read_en  = re;
      @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      write_en = 1'b0;
      write_dt = '0;
      read_en  = 1'b0;
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Idle after reset
      repeat (5) cyc(1'b0, '0, 1'b0);
      check_n("rst_empty", int'(empty), 1);
      check_n("rst_full",  int'(full),  0);
      check_n("rst_count", int'(count), 0);
      check_w("rst_read_dt", read_dt, '0);
      check_n("rst_errs", int'({overflow, underflow}), 0);

      // Three spaced writes, then a long read burst
      cyc(1'b1, word_of(32'hA), 1'b0); check_n("cnt1", int'(count), 1);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b1, word_of(32'hB), 1'b0); check_n("cnt2", int'(count), 2);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b1, word_of(32'hC), 1'b0); check_n("cnt3", int'(count), 3);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b1); check_w("rd_a", read_dt, word_of(32'hA));
      cyc(1'b0, '0, 1'b1); check_w("rd_b", read_dt, word_of(32'hB));
      cyc(1'b0, '0, 1'b1); check_w("rd_c", read_dt, word_of(32'hC));
      check_n("empty_after_c", int'(empty), 1);
      check_n("no_udf_yet", int'(underflow), 0);
      cyc(1'b0, '0, 1'b1); check_n("udf1", int'(underflow), 1);
      check_w("hold_c1", read_dt, word_of(32'hC));
      cyc(1'b0, '0, 1'b1); check_n("udf2", int'(underflow), 1);
      check_w("hold_c2", read_dt, word_of(32'hC));
      cyc(1'b0, '0, 1'b0); check_n("udf_clear", int'(underflow), 0);

      // Fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, word_of(i), 1'b0);
      check_n("fill_full", int'(full), 1);
      check_n("fill_count", int'(count), 16);
      cyc(1'b1, word_of(32'h99), 1'b0);
      check_n("ovf_pulse", int'(overflow), 1);
      check_n("ovf_count", int'(count), 16);
      cyc(1'b0, '0, 1'b0); check_n("ovf_once", int'(overflow), 0);
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b0, '0, 1'b1);
         check_w("drain", read_dt, word_of(i));
      end
      check_n("drain_empty", int'(empty), 1);
      cyc(1'b0, '0, 1'b0);

      // Simultaneous read and write while full
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, word_of(32'h10 + i), 1'b0);
      cyc(1'b1, word_of(32'h55), 1'b1);
      check_w("rw_full_rd", read_dt, word_of(32'h10));
      check_n("rw_full_count", int'(count), 16);
      check_n("rw_full_ovf", int'(overflow), 0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);
      check_w("rw_full_last", read_dt, word_of(32'h55));
      cyc(1'b0, '0, 1'b0);

      // Interleaved pairs across several pointer wraps
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, pat(i), 1'b0);
         check_n("wrap_cnt1", int'(count), 1);
         cyc(1'b0, '0, 1'b1);
         check_w("wrap_rd", read_dt, pat(i));
         check_n("wrap_cnt0", int'(count), 0);
      end

      // Reset with data stored and a coincident write
      for (int i = 0; i < 5; i++) cyc(1'b1, word_of(32'h20 + i), 1'b0);
      rst = 1'b1;
      cyc(1'b1, word_of(32'h77), 1'b0);
      rst = 1'b0;
      check_n("mid_rst_count", int'(count), 0);
      check_n("mid_rst_empty", int'(empty), 1);
      check_w("mid_rst_rd", read_dt, '0);
      cyc(1'b0, '0, 1'b1);
      check_n("mid_rst_udf", int'(underflow), 1);
      check_w("mid_rst_nostore", read_dt, '0);
      cyc(1'b1, word_of(32'h5A), 1'b0);
      cyc(1'b0, '0, 1'b1);
      check_w("post_rst_rd", read_dt, word_of(32'h5A));
      cyc(1'b0, '0, 1'b0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
